summand_feeder: RTL and testbench
=================================

# summand_feeder

Upstream feeder for the 8-bit accumulator. It buffers incoming samples from a valid/ready producer in a small FIFO and issues one summand per cycle, together with a one-cycle clock-enable strobe, to the accumulator's `i_SUMMAND`/`i_CLK_EN` inputs. It also counts the summands issued per frame. After every `FRAME_LEN` summands it raises a frame-done marker and then a one-cycle accumulator clear.

## Interface
- `DATA_WIDTH`, default 8: sample and summand width; matches the accumulator input.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `FRAME_LEN`, default 16: summands per frame; range 2..255.
- `i_CLK`, in, 1: the block's single clock; all logic is on the rising edge.
- `i_RESET`, in, 1: reset, synchronous and active-low. Resets all state on the rising edge of `i_CLK` while low.
- `i_VALID`, in, 1: a producer sample is present.
- `i_DATA`, in, `DATA_WIDTH`: producer sample.
- `o_READY`, out, 1: the FIFO can accept a sample; high when `level < FIFO_DEPTH`.
- `i_HOLD`, in, 1: downstream stall; while high, no summand is issued.
- `o_CLK_EN`, out, 1: strobe to the accumulator `i_CLK_EN`; high for exactly one cycle per issued summand.
- `o_SUMMAND`, out, `DATA_WIDTH`: to the accumulator `i_SUMMAND`; valid whenever `o_CLK_EN` is high.
- `o_FRAME_DONE`, out, 1: high together with the strobe that issues the last summand of a frame.
- `o_ACC_CLEAR`, out, 1: one-cycle clear request to the accumulator reset; active-high.
- `o_LEVEL`, out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
Push and pop:
- A push occurs when `i_VALID && o_READY`; the sample is written at the tail.
- A pop occurs when the FIFO is non-empty, `i_HOLD` is low, and the state is RUN.
- Push and pop in the same cycle leave `o_LEVEL` unchanged. This applies at every level except full, where `o_READY` is low and no push can occur.
- Push while the FIFO is empty does not fall through. The sample enters the FIFO first and pops on a later edge.

Output register:
- On a pop, `o_SUMMAND` loads the head entry and `o_CLK_EN` goes to 1.
- With no pop, `o_CLK_EN` goes to 0 and `o_SUMMAND` holds its last value.

Frame counter:
- `frame_cnt` ranges 0..FRAME_LEN-1 and increments on each pop.
- On the pop taken while `frame_cnt == FRAME_LEN-1`, the counter wraps to 0 and `o_FRAME_DONE` is registered high alongside that `o_CLK_EN`.

State machine:
- RUN: pops are allowed. On the pop that completes a frame, move to CLEAR.
- CLEAR: lasts one cycle. `o_ACC_CLEAR` is high, no pop occurs, pushes are still accepted. Then return to RUN.
- The clear is therefore asserted one cycle after the last summand strobe of the frame. The accumulator captures that summand before it is cleared.

Arithmetic:
- No arithmetic on the data path; samples pass through unmodified.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo the depth.
- The level counter is one bit wider than the pointers, so full and empty are distinct.

Reset (`i_RESET` low, including mid-frame):
- FIFO is flushed, pointers and `frame_cnt` are 0, state is RUN.
- `o_CLK_EN`, `o_SUMMAND`, `o_FRAME_DONE`, `o_ACC_CLEAR` and `o_LEVEL` are all 0.
- `o_READY` is 1 one cycle after release.
- A push attempted during reset is discarded.

## Timing
- Latency: a sample pushed on edge k produces `o_CLK_EN` high after edge k+1 at the earliest.
- Throughput: one summand per cycle while data is available, except for the single CLEAR bubble per frame.
- All outputs are registered except `o_READY`, which is decoded combinationally from the level register.
- `i_HOLD` takes effect on the same edge: if `i_HOLD` is high on edge k, `o_CLK_EN` is 0 after edge k.
- `i_HOLD` during CLEAR has no effect; CLEAR still lasts exactly one cycle.

## Structure
- Shared package `acc_pkg` holds `DATA_WIDTH`, the state enum {RUN, CLEAR} and the `$clog2`-derived width constants.
- The storage is a natural sub-module: `sync_fifo` (parameterised depth/width, push/pop/level, synchronous active-low reset).
- The top level holds the output register, frame counter and FSM.

## Test plan
- Reset, then push 1, 2, 3 on consecutive cycles with `i_HOLD`=0 -> `o_CLK_EN` high for 3 consecutive cycles, the first on the cycle after the first push edge. `o_SUMMAND` = 1, 2, 3. `o_LEVEL` returns to 0.
- Hold `i_HOLD`=1 and push 5 samples -> exactly 4 are accepted and `o_READY`=0 at `o_LEVEL`=4. Release the hold -> 4 strobes follow in order, and `o_READY` rises on the first pop.
- Stream 16 samples of value 0x01 (`FRAME_LEN`=16) -> `o_FRAME_DONE` is high with the 16th strobe. `o_ACC_CLEAR` is high the next cycle with `o_CLK_EN`=0. Strobes resume the cycle after.
- Keep the FIFO full while continuously pushing and popping -> `o_LEVEL` stays constant, and output order matches input order across pointer wrap (at least 3 wraps).
- Assert `i_RESET` low for one cycle after the 7th summand of a frame -> all outputs are 0. The next frame needs a full 16 summands before `o_FRAME_DONE`.
- Push and pop on the same edge at `o_LEVEL`=1 -> the level stays at 1 and the pushed value is issued on the following cycle.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator feeder: default sizes, FSM states
// and width helpers derived from the FIFO depth and frame length.
package acc_pkg;

  // Default for DATA_WIDTH: matches the accumulator summand input.
  localparam int DFLT_DATA_WIDTH = 8;
  localparam int DFLT_FIFO_DEPTH = 4;
  localparam int DFLT_FRAME_LEN  = 16;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // FIFO read/write pointer width; pointers wrap modulo the depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one bit wider than the pointers so full != empty.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Frame counter width, enough to hold FRAME_LEN-1.
  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers/level; head entry is read
// combinationally so the consumer can register it on the pop edge.
module sync_fifo
  import acc_pkg::*;
#(
  parameter int WIDTH = DFLT_DATA_WIDTH,
  parameter int DEPTH = DFLT_FIFO_DEPTH
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic                    i_PUSH,
  input  logic [WIDTH-1:0]        i_DATA,
  input  logic                    i_POP,
  output logic [WIDTH-1:0]        o_HEAD,
  output logic [lvl_w(DEPTH)-1:0] o_LEVEL
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow guards keep the pointers consistent even if misused.
  assign do_push = i_PUSH && (level != LVL_FULL);
  assign do_pop  = i_POP && (level != '0);

  // Storage write; a push during reset is dropped.
  always_ff @(posedge i_CLK) begin
    if (i_RESET && do_push) begin
      mem[wr_ptr] <= i_DATA;
    end
  end

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_HEAD  = mem[rd_ptr];
  assign o_LEVEL = level;

endmodule

// File: rtl/summand_feeder.sv
// Feeds the 8-bit accumulator: buffers producer samples, issues one summand
// per cycle with a clock-enable strobe, and clears the accumulator after
// every FRAME_LEN summands.
module summand_feeder
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DFLT_FIFO_DEPTH,
  parameter int FRAME_LEN  = DFLT_FRAME_LEN
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET,
  input  logic                         i_VALID,
  input  logic [DATA_WIDTH-1:0]        i_DATA,
  output logic                         o_READY,
  input  logic                         i_HOLD,
  output logic                         o_CLK_EN,
  output logic [DATA_WIDTH-1:0]        o_SUMMAND,
  output logic                         o_FRAME_DONE,
  output logic                         o_ACC_CLEAR,
  output logic [lvl_w(FIFO_DEPTH)-1:0] o_LEVEL
);

  localparam int LVL_W = lvl_w(FIFO_DEPTH);
  localparam int CNT_W = cnt_w(FRAME_LEN);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_t                state_p0;
  state_t                state_nxt;
  logic [CNT_W-1:0]      frame_cnt_p0;
  logic [LVL_W-1:0]      level;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;
  logic                  frame_end;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] summand_p1;
  logic                  frame_done_p1;
  logic                  acc_clear_p1;

  // Ready comes straight from the level register so it never depends on pop.
  assign o_READY   = (level < LVL_FULL);
  assign push      = i_VALID && o_READY;
  assign pop       = (level != '0) && !i_HOLD && (state_p0 == RUN);
  assign frame_end = pop && (frame_cnt_p0 == CNT_LAST);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_PUSH  (push),
    .i_DATA  (i_DATA),
    .i_POP   (pop),
    .o_HEAD  (head),
    .o_LEVEL (level)
  );

  // Next state: the frame-completing pop forces a one-cycle CLEAR bubble.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      RUN:     if (frame_end) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Stage p0: FSM state and frame position, advanced on each pop.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state_p0     <= RUN;
      frame_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (pop) begin
        frame_cnt_p0 <= frame_end ? '0 : frame_cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Stage p1: registered accumulator interface; summand holds between strobes.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      vld_p1        <= 1'b0;
      summand_p1    <= '0;
      frame_done_p1 <= 1'b0;
      acc_clear_p1  <= 1'b0;
    end else begin
      vld_p1        <= pop;
      frame_done_p1 <= frame_end;
      acc_clear_p1  <= (state_p0 == CLEAR);
      if (pop) begin
        summand_p1 <= head;
      end
    end
  end

  assign o_CLK_EN     = vld_p1;
  assign o_SUMMAND    = summand_p1;
  assign o_FRAME_DONE = frame_done_p1;
  assign o_ACC_CLEAR  = acc_clear_p1;
  assign o_LEVEL      = level;

endmodule

// File: tb/tb_summand_feeder.sv
// Self-checking bench for summand_feeder: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_summand_feeder;

  localparam int DEPTH = 4;
  localparam int FL    = 16;

  logic       i_CLK = 1'b0;
  logic       i_RESET = 1'b0;
  logic       i_VALID = 1'b0;
  logic [7:0] i_DATA = 8'h00;
  logic       i_HOLD = 1'b0;
  logic       o_READY;
  logic       o_CLK_EN;
  logic [7:0] o_SUMMAND;
  logic       o_FRAME_DONE;
  logic       o_ACC_CLEAR;
  logic [2:0] o_LEVEL;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents as a queue, summands issued in the
  // current frame, and whether the next edge is the clear bubble.
  logic [7:0] q[$];
  int         m_cnt = 0;
  bit         m_blocked = 0;
  logic [7:0] m_summand = 8'h00;
  bit         exp_clk_en, exp_fd, exp_clear, exp_push;
  int         exp_level;

  summand_feeder #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FL)
  ) dut (
    .i_CLK        (i_CLK),
    .i_RESET      (i_RESET),
    .i_VALID      (i_VALID),
    .i_DATA       (i_DATA),
    .o_READY      (o_READY),
    .i_HOLD       (i_HOLD),
    .o_CLK_EN     (o_CLK_EN),
    .o_SUMMAND    (o_SUMMAND),
    .o_FRAME_DONE (o_FRAME_DONE),
    .o_ACC_CLEAR  (o_ACC_CLEAR),
    .o_LEVEL      (o_LEVEL)
  );

  always #5 i_CLK = ~i_CLK;

  // Drive one cycle, advance the model, and return sampled #1 after the edge.
  task automatic cycle(input logic rst_n, input logic v, input logic [7:0] d, input logic h);
    bit push, pop;
    i_RESET = rst_n;
    i_VALID = v;
    i_DATA  = d;
    i_HOLD  = h;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      m_blocked = 0;
      m_summand = 8'h00;
      exp_clk_en = 0;
      exp_fd = 0;
      exp_clear = 0;
      exp_push = 0;
    end else begin
      push = v && (q.size() < DEPTH);
      pop  = !m_blocked && (q.size() > 0) && !h;
      exp_clear  = m_blocked;
      exp_clk_en = pop;
      exp_fd     = 0;
      m_blocked  = 0;
      if (pop) begin
        m_summand = q.pop_front();
        m_cnt++;
        if (m_cnt == FL) begin
          m_cnt = 0;
          exp_fd = 1;
          m_blocked = 1;
        end
      end
      if (push) q.push_back(d);
      exp_push = push;
    end
    exp_level = q.size();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 1'b1, 8'hBB, 1'b0);
    n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en got %b want 0", o_CLK_EN); end
    n_tests++; if (o_SUMMAND !== 8'h00) begin n_fail++; $display("FAIL reset_summand got %h want 00", o_SUMMAND); end
    n_tests++; if (o_FRAME_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", o_FRAME_DONE); end
    n_tests++; if (o_ACC_CLEAR !== 1'b0) begin n_fail++; $display("FAIL reset_acc_clear got %b want 0", o_ACC_CLEAR); end
    n_tests++; if (o_LEVEL !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", o_LEVEL); end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (o_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_READY); end
    n_tests++; if (o_LEVEL !== 3'd0) begin n_fail++; $display("FAIL reset_push_discard level got %0d want 0", o_LEVEL); end
  endtask

  task automatic test_basic();
    logic [7:0] want [3] = '{8'd1, 8'd2, 8'd3};
    do_reset();
    cycle(1'b1, 1'b1, 8'd1, 1'b0);
    n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL basic_no_fallthrough clk_en got %b want 0", o_CLK_EN); end
    n_tests++; if (o_LEVEL !== 3'd1) begin n_fail++; $display("FAIL basic_level1 got %0d want 1", o_LEVEL); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, (i < 2), 8'(i + 2), 1'b0);
      n_tests++; if (o_CLK_EN !== 1'b1) begin n_fail++; $display("FAIL basic_strobe%0d got %b want 1", i, o_CLK_EN); end
      n_tests++; if (o_SUMMAND !== want[i]) begin n_fail++; $display("FAIL basic_summand%0d got %0d want %0d", i, o_SUMMAND, want[i]); end
    end
    n_tests++; if (o_LEVEL !== 3'd0) begin n_fail++; $display("FAIL basic_level_end got %0d want 0", o_LEVEL); end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL basic_idle clk_en got %b want 0", o_CLK_EN); end
  endtask

  task automatic test_fill_hold();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'(10 + i), 1'b1);
      n_tests++;
      if (o_LEVEL !== 3'((i < 4) ? i + 1 : 4)) begin
        n_fail++; $display("FAIL hold_level%0d got %0d want %0d", i, o_LEVEL, (i < 4) ? i + 1 : 4);
      end
      n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL hold_no_strobe%0d got %b want 0", i, o_CLK_EN); end
    end
    n_tests++; if (o_READY !== 1'b0) begin n_fail++; $display("FAIL hold_full_ready got %b want 0", o_READY); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      n_tests++; if (o_CLK_EN !== 1'b1) begin n_fail++; $display("FAIL drain_strobe%0d got %b want 1", i, o_CLK_EN); end
      n_tests++; if (o_SUMMAND !== 8'(10 + i)) begin n_fail++; $display("FAIL drain_summand%0d got %0d want %0d", i, o_SUMMAND, 10 + i); end
      if (i == 0) begin
        n_tests++; if (o_READY !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise got %b want 1", o_READY); end
      end
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL drain_fifth got %b want 0", o_CLK_EN); end
  endtask

  task automatic test_frame();
    bit ce [24];
    bit fd [24];
    bit cl [24];
    int strobes = 0;
    int fd_strobe = -1;
    int fd_at = -1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, (i < 20), 8'h01, 1'b0);
      ce[i] = o_CLK_EN; fd[i] = o_FRAME_DONE; cl[i] = o_ACC_CLEAR;
      if (o_CLK_EN === 1'b1) strobes++;
      if (o_FRAME_DONE === 1'b1 && fd_at < 0) begin fd_at = i; fd_strobe = strobes; end
      n_tests++;
      if (o_CLK_EN !== exp_clk_en || o_FRAME_DONE !== exp_fd || o_ACC_CLEAR !== exp_clear) begin
        n_fail++;
        $display("FAIL frame_cycle%0d got ce/fd/clr %b%b%b want %b%b%b", i, o_CLK_EN, o_FRAME_DONE, o_ACC_CLEAR, exp_clk_en, exp_fd, exp_clear);
      end
    end
    n_tests++;
    if (fd_at < 0 || fd_at > 21) begin
      n_fail++; $display("FAIL frame_done_seen got index %0d want 1..21", fd_at);
    end else begin
      if (fd_strobe != 16) begin n_fail++; $display("FAIL frame_done_position got strobe %0d want 16", fd_strobe); end
      n_tests++; if (ce[fd_at] !== 1'b1) begin n_fail++; $display("FAIL frame_done_with_strobe got %b want 1", ce[fd_at]); end
      n_tests++; if (cl[fd_at + 1] !== 1'b1) begin n_fail++; $display("FAIL frame_clear_next got %b want 1", cl[fd_at + 1]); end
      n_tests++; if (ce[fd_at + 1] !== 1'b0) begin n_fail++; $display("FAIL frame_clear_bubble got %b want 0", ce[fd_at + 1]); end
      n_tests++; if (ce[fd_at + 2] !== 1'b1) begin n_fail++; $display("FAIL frame_resume got %b want 1", ce[fd_at + 2]); end
      n_tests++; if (fd[fd_at + 1] !== 1'b0 || cl[fd_at + 2] !== 1'b0) begin n_fail++; $display("FAIL frame_single_cycle fd %b clr %b want 0 0", fd[fd_at + 1], cl[fd_at + 2]); end
    end
  endtask

  task automatic test_full_stream();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
      n_tests++; if (o_LEVEL !== 3'd3) begin n_fail++; $display("FAIL full_level%0d got %0d want 3", i, o_LEVEL); end
      n_tests++;
      if (o_CLK_EN !== 1'b1 || o_SUMMAND !== m_summand) begin
        n_fail++; $display("FAIL full_order%0d got ce %b val %h want 1 %h", i, o_CLK_EN, o_SUMMAND, m_summand);
      end
    end
  endtask

  task automatic test_mid_reset();
    int s = 0;
    int n = 0;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 20 && s < 7; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
      if (o_CLK_EN === 1'b1) s++;
    end
    n_tests++; if (s != 7) begin n_fail++; $display("FAIL midrst_reach7 got %0d want 7", s); end
    cycle(1'b0, 1'b1, 8'h55, 1'b0);
    n_tests++;
    if ({o_CLK_EN, o_SUMMAND, o_FRAME_DONE, o_ACC_CLEAR, o_LEVEL} !== 14'd0) begin
      n_fail++; $display("FAIL midrst_outputs got ce%b s%h fd%b clr%b lvl%0d want all 0", o_CLK_EN, o_SUMMAND, o_FRAME_DONE, o_ACC_CLEAR, o_LEVEL);
    end
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    n_tests++; if (o_CLK_EN !== 1'b0) begin n_fail++; $display("FAIL midrst_discard got %b want 0", o_CLK_EN); end
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
      if (o_CLK_EN === 1'b1) n++;
      if (o_FRAME_DONE === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen || n != 16) begin n_fail++; $display("FAIL midrst_full_frame got seen %0d strobes %0d want 1 16", seen, n); end
  endtask

  task automatic test_same_edge();
    do_reset();
    cycle(1'b1, 1'b1, 8'h42, 1'b0);
    cycle(1'b1, 1'b1, 8'h43, 1'b0);
    n_tests++; if (o_LEVEL !== 3'd1) begin n_fail++; $display("FAIL same_edge_level got %0d want 1", o_LEVEL); end
    n_tests++; if (o_SUMMAND !== 8'h42 || o_CLK_EN !== 1'b1) begin n_fail++; $display("FAIL same_edge_first got %b %h want 1 42", o_CLK_EN, o_SUMMAND); end
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (o_SUMMAND !== 8'h43 || o_CLK_EN !== 1'b1) begin n_fail++; $display("FAIL same_edge_next got %b %h want 1 43", o_CLK_EN, o_SUMMAND); end
    n_tests++; if (o_LEVEL !== 3'd0) begin n_fail++; $display("FAIL same_edge_empty got %0d want 0", o_LEVEL); end
  endtask

  task automatic test_random();
    logic rst_n, v, h;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      v     = ($urandom_range(0, 3) != 0);
      h     = ($urandom_range(0, 3) == 0);
      d     = 8'($urandom);
      cycle(rst_n, v, d, h);
      n_tests++;
      if (o_CLK_EN !== exp_clk_en || o_SUMMAND !== m_summand) begin
        n_fail++; $display("FAIL rand_data%0d got %b %h want %b %h", i, o_CLK_EN, o_SUMMAND, exp_clk_en, m_summand);
      end
      n_tests++;
      if (o_FRAME_DONE !== exp_fd || o_ACC_CLEAR !== exp_clear) begin
        n_fail++; $display("FAIL rand_frame%0d got fd %b clr %b want %b %b", i, o_FRAME_DONE, o_ACC_CLEAR, exp_fd, exp_clear);
      end
      n_tests++;
      if (o_LEVEL !== 3'(exp_level) || o_READY !== (exp_level < DEPTH)) begin
        n_fail++; $display("FAIL rand_level%0d got %0d rdy %b want %0d %b", i, o_LEVEL, o_READY, exp_level, exp_level < DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_hold();
    test_frame();
    test_full_stream();
    test_mid_reset();
    test_same_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
